// File: rtl/lenvelope_follower_if.sv
// Sample-stream bundle for lenvelope_follower.
// Master drives samples in and receives the aligned envelope out.
interface lenvelope_follower_if #(
  parameter int DATA_W = 8
);
  logic              i_ce;
  logic [DATA_W-1:0] i_data;
  logic              o_ce;
  logic [DATA_W-1:0] o_data;
  logic [DATA_W-2:0] o_env;

  modport master (
    output i_ce, i_data,
    input  o_ce, o_data, o_env
  );

  modport slave (
    input  i_ce, i_data,
    output o_ce, o_data, o_env
  );
endinterface

// File: rtl/lenvelope_follower.sv
// Peak-magnitude envelope follower with attack/hold/release smoothing.
// Two-stage pipeline; delayed samples stay aligned with the envelope.
module lenvelope_follower #(
  parameter int DATA_W        = 8,
  parameter int ENV_W         = 16,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int HOLD_SAMPLES  = 16
) (
  input logic i_clk,
  input logic i_reset_n,
  lenvelope_follower_if.slave bus
);

  localparam int MAG_W = DATA_W - 1;
  localparam int FRAC  = ENV_W - MAG_W;
  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_SAMPLES);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    HOLD,
    RELEASE
  } state_e;

  logic [DATA_W-1:0] abs_v;
  logic [MAG_W-1:0]  mag;
  logic [ENV_W-1:0]  tgt_d;

  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [ENV_W-1:0]  s1_tgt_q;

  logic [ENV_W-1:0]  env_q, env_d;
  state_e            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ENV_W-1:0]  diff_up, att, sum_up, env_up;
  logic [ENV_W-1:0]  diff_dn, rel, env_dn;

  logic              o_ce_q;
  logic [DATA_W-1:0] o_data_q;
  logic [MAG_W-1:0]  o_env_q;

  // Magnitude; only the most negative sample sets the top bit, so saturate it.
  always_comb begin
    abs_v = bus.i_data[DATA_W-1] ? (~bus.i_data + DATA_W'(1)) : bus.i_data;
    mag   = abs_v[DATA_W-1] ? '1 : abs_v[MAG_W-1:0];
    tgt_d = {mag, {FRAC{1'b0}}};
  end

  // Stage 1: capture sample and its target on the strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_tgt_q  <= '0;
    end else begin
      s1_vld_q <= bus.i_ce;
      if (bus.i_ce) begin
        s1_data_q <= bus.i_data;
        s1_tgt_q  <= tgt_d;
      end
    end
  end

  // Attack and release step candidates, each clamped at the target.
  always_comb begin
    diff_up = s1_tgt_q - env_q;
    att     = diff_up >> ATTACK_SHIFT;
    if (att == '0) att = ENV_W'(1);
    sum_up  = env_q + att;
    env_up  = (sum_up > s1_tgt_q) ? s1_tgt_q : sum_up;
    diff_dn = env_q - s1_tgt_q;
    rel     = diff_dn >> RELEASE_SHIFT;
    if (rel == '0) rel = ENV_W'(1);
    env_dn  = (rel >= diff_dn) ? s1_tgt_q : (env_q - rel);
  end

  // Envelope state machine, advanced once per stage-2 sample.
  always_comb begin
    env_d = env_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    if (s1_vld_q) begin
      if (s1_tgt_q > env_q) begin
        env_d = env_up;
        if (env_up == s1_tgt_q) begin
          st_d  = HOLD;
          cnt_d = HOLD_CNT;
        end else begin
          st_d = ATTACK;
        end
      end else begin
        unique case (st_q)
          IDLE: ;
          ATTACK: begin
            st_d  = HOLD;
            cnt_d = HOLD_CNT;
          end
          HOLD: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) st_d = RELEASE;
          end
          RELEASE: begin
            if (env_q > s1_tgt_q) begin
              env_d = env_dn;
              if (env_dn == '0) st_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Stage 2: envelope state plus aligned output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      env_q    <= '0;
      st_q     <= IDLE;
      cnt_q    <= '0;
      o_ce_q   <= 1'b0;
      o_data_q <= '0;
      o_env_q  <= '0;
    end else begin
      env_q  <= env_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      o_ce_q <= s1_vld_q;
      if (s1_vld_q) begin
        o_data_q <= s1_data_q;
        o_env_q  <= env_d[ENV_W-1:FRAC];
      end
    end
  end

  assign bus.o_ce   = o_ce_q;
  assign bus.o_data = o_data_q;
  assign bus.o_env  = o_env_q;

endmodule

// File: tb/tb_lenvelope_follower.sv
// Self-checking bench for lenvelope_follower.
// Directed scenarios plus random traffic against a per-sample model.
module tb_lenvelope_follower;

  localparam int DATA_W = 8;
  localparam int ENV_W  = 16;
  localparam int ASH    = 2;
  localparam int RSH    = 6;
  localparam int HS     = 16;
  localparam int FRAC   = ENV_W - (DATA_W - 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  lenvelope_follower_if #(.DATA_W(DATA_W)) bus ();

  lenvelope_follower #(
    .DATA_W       (DATA_W),
    .ENV_W        (ENV_W),
    .ATTACK_SHIFT (ASH),
    .RELEASE_SHIFT(RSH),
    .HOLD_SAMPLES (HS)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 attack, 2 hold, 3 release.
  int m_env, m_st, m_hold;

  // One sample in flight between input and output, plus held outputs.
  bit         p_v;
  logic [7:0] p_d;
  int         p_e;
  logic [7:0] h_d;
  int         h_e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_sample(input logic [7:0] d);
    int s, mag, tgt, step;
    s   = $signed(d);
    mag = (s < 0) ? -s : s;
    if (mag > 127) mag = 127;
    tgt = mag * (1 << FRAC);
    if (tgt > m_env) begin
      step = (tgt - m_env) / (1 << ASH);
      if (step < 1) step = 1;
      m_env = m_env + step;
      if (m_env > tgt) m_env = tgt;
      if (m_env == tgt) begin
        m_st   = 2;
        m_hold = HS;
      end else begin
        m_st = 1;
      end
    end else if (m_st == 1) begin
      m_st   = 2;
      m_hold = HS;
    end else if (m_st == 2) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_st = 3;
    end else if (m_st == 3 && m_env > tgt) begin
      step = (m_env - tgt) / (1 << RSH);
      if (step < 1) step = 1;
      m_env = m_env - step;
      if (m_env < tgt) m_env = tgt;
      if (m_env == 0) m_st = 0;
    end
    return m_env / (1 << FRAC);
  endfunction

  task automatic tick(input bit ce, input logic [7:0] d);
    bit         ev;
    logic [7:0] ed;
    int         ee;
    bus.i_ce   = ce;
    bus.i_data = d;
    @(posedge clk);
    ev = p_v;
    ed = p_d;
    ee = p_e;
    p_v = ce && rst_n;
    if (p_v) begin
      p_d = d;
      p_e = model_sample(d);
    end
    #1;
    if (ev) begin
      h_d = ed;
      h_e = ee;
    end
    chk("o_ce", 32'(bus.o_ce), 32'(ev));
    chk("o_data", 32'(bus.o_data), 32'(h_d));
    chk("o_env", 32'(bus.o_env), 32'(h_e));
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    m_env  = 0;
    m_st   = 0;
    m_hold = 0;
    p_v    = 1'b0;
    h_d    = '0;
    h_e    = 0;
    #1;
    chk("rst_ce", 32'(bus.o_ce), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_env", 32'(bus.o_env), 0);
    for (int i = 0; i < n; i++) tick(i[0], 8'h55);
    rst_n = 1'b1;
  endtask

  task automatic attack_to(input logic [7:0] d, input int lvl);
    for (int i = 0; i < 200 && m_env != lvl * (1 << FRAC); i++)
      tick(1'b1, d);
    tick(1'b0, 8'h00);
    chk("peak", 32'(bus.o_env), 32'(lvl));
  endtask

  initial begin
    int e0;
    bus.i_ce   = 1'b0;
    bus.i_data = '0;
    #2;
    do_reset(5);

    // Attack from reset toward 100.
    for (int i = 0; i < 200 && m_env != 100 * (1 << FRAC); i++) begin
      tick(1'b1, 8'd100);
      if (i == 1) chk("att1", 32'(bus.o_env), 25);
      if (i == 2) chk("att2", 32'(bus.o_env), 43);
      if (i == 3) chk("att3", 32'(bus.o_env), 57);
      if (i >= 1) chk("att_data", 32'(bus.o_data), 100);
    end
    tick(1'b0, 8'h00);
    chk("att_peak", 32'(bus.o_env), 100);

    // Hold for 16 samples, first release step on the 17th.
    for (int i = 0; i < 17; i++) tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    chk("rel_first", 32'(bus.o_env), 98);

    // Decay to idle.
    for (int i = 0; i < 3000 && m_st != 0; i++) tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    chk("decay_zero", 32'(bus.o_env), 0);

    // Re-attack mid-release with gapped strobes.
    attack_to(8'd100, 100);
    for (int i = 0; i < HS + 40; i++) tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    e0 = int'(bus.o_env);
    for (int i = 0; i < 300 && !(m_st == 2 && m_env == 120 * (1 << FRAC));
         i++) begin
      tick(1'b1, 8'h88);
      tick(1'b0, 8'h11);
      if (i == 0) chk("reatk_rise", 32'(int'(bus.o_env) > e0), 1);
      tick(1'b0, 8'h22);
    end
    chk("reatk_peak", 32'(bus.o_env), 120);

    // Saturating magnitude.
    do_reset(1);
    tick(1'b1, 8'h80);
    tick(1'b0, 8'h00);
    chk("sat_ce", 32'(bus.o_ce), 1);
    chk("sat_data", 32'(bus.o_data), 32'h80);
    chk("sat_env", 32'(bus.o_env), 31);

    // Reset one cycle after a strobe drops that sample.
    tick(1'b1, 8'd40);
    do_reset(2);
    tick(1'b1, 8'd40);
    tick(1'b0, 8'h00);
    chk("post_rst_env", 32'(bus.o_env), 10);

    // Random traffic.
    for (int blk = 0; blk < 30; blk++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 100; i++) begin
        logic [7:0] d;
        bit ce;
        ce = ($urandom_range(0, 3) != 0);
        d  = 8'($urandom);
        if (mode == 0) d = 8'h00;
        if (mode == 1) d = 8'($signed($urandom_range(0, 16)) - 8);
        tick(ce, d);
      end
    end
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
